// File: rtl/photobooth_pkg.sv
// Shared types and helpers for the photobooth sequencer: state encoding,
// filter indices and the saturating threshold adjustment.
package photobooth_pkg;

    typedef enum logic [2:0] {
        PB_IDLE      = 3'd0,
        PB_PHOTO     = 3'd1,
        PB_CHOOSE    = 3'd2,
        PB_THRESHOLD = 3'd3,
        PB_SEND      = 3'd4
    } pb_state_t;

    localparam logic [1:0] FILT_GRAY   = 2'd0;
    localparam logic [1:0] FILT_DITHER = 2'd1;
    localparam logic [1:0] FILT_THRESH = 2'd2;

    // One extra bit of headroom exposes overflow/underflow so the result can be clamped.
    function automatic logic [7:0] thresh_adjust(
        input logic [7:0] level,
        input logic [7:0] step,
        input logic       up
    );
        logic [8:0] wide;
        if (up) begin
            wide = {1'b0, level} + {1'b0, step};
            thresh_adjust = wide[8] ? 8'hFF : wide[7:0];
        end else begin
            wide = {1'b0, level} - {1'b0, step};
            thresh_adjust = wide[8] ? 8'h00 : wide[7:0];
        end
    endfunction

endpackage

// File: rtl/pb_second_tick.sv
// Prescaler producing a one-cycle tick every CLK_HZ cycles; held at zero while
// clear_in is high so the first tick lands a full second after release.
module pb_second_tick #(
    parameter int CLK_HZ = 65_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_out = !clear_in && (count == LAST);

endmodule

// File: rtl/photobooth_ctrl.sv
// Photobooth flow sequencer: countdown and frame-aligned capture, filter and
// threshold selection, then hand-off to the send path.
module photobooth_ctrl
    import photobooth_pkg::*;
#(
    parameter int CLK_HZ         = 65_000_000,
    parameter int COUNTDOWN_S    = 3,
    parameter int NUM_FILTERS    = 3,
    parameter int THRESH_DEFAULT = 128,
    parameter int THRESH_STEP    = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_done_in,
    input  logic       frame_done_in,
    input  logic       btnl_in,
    input  logic       btnr_in,
    input  logic       btnc_in,
    input  logic       send_done_in,
    output logic [2:0] state_out,
    output logic       cam_write_en_out,
    output logic [3:0] countdown_out,
    output logic [1:0] filter_sel_out,
    output logic [7:0] threshold_out,
    output logic       send_start_out
);

    localparam logic [3:0] COUNT_INIT = 4'(COUNTDOWN_S);
    localparam logic [1:0] FILT_LAST  = 2'(NUM_FILTERS - 1);
    localparam logic [7:0] THR_INIT   = 8'(THRESH_DEFAULT);
    localparam logic [7:0] THR_STEP   = 8'(THRESH_STEP);

    pb_state_t  state_q, state_d;
    logic [3:0] countdown_q, countdown_d;
    logic [1:0] filter_q, filter_d;
    logic [7:0] threshold_q, threshold_d;
    logic       cam_we_q, cam_we_d;
    logic       send_start_q, send_start_d;
    logic       armed_q, armed_d;
    logic [2:0] btn_prev_q;
    logic [2:0] btn_cur;
    logic [2:0] btn_rise;
    logic       rise_l, rise_r, rise_c;
    logic       sec_tick;

    pb_second_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_second_tick (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .clear_in(state_q != PB_PHOTO),
        .tick_out(sec_tick)
    );

    assign btn_cur  = {btnc_in, btnr_in, btnl_in};
    assign btn_rise = btn_cur & ~btn_prev_q;
    assign rise_l   = btn_rise[0];
    assign rise_r   = btn_rise[1];
    assign rise_c   = btn_rise[2];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= PB_IDLE;
            countdown_q  <= '0;
            filter_q     <= FILT_GRAY;
            threshold_q  <= THR_INIT;
            cam_we_q     <= 1'b1;
            send_start_q <= 1'b0;
            armed_q      <= 1'b0;
            // Buttons held through reset must not register as a press.
            btn_prev_q   <= '1;
        end else begin
            state_q      <= state_d;
            countdown_q  <= countdown_d;
            filter_q     <= filter_d;
            threshold_q  <= threshold_d;
            cam_we_q     <= cam_we_d;
            send_start_q <= send_start_d;
            armed_q      <= armed_d;
            btn_prev_q   <= btn_cur;
        end
    end

    always_comb begin
        // NOTE: every value gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        countdown_d  = countdown_q;
        filter_d     = filter_q;
        threshold_d  = threshold_q;
        cam_we_d     = cam_we_q;
        send_start_d = 1'b0;
        armed_d      = armed_q;

        case (state_q)
            PB_IDLE: begin
                if (start_done_in) begin
                    state_d     = PB_PHOTO;
                    countdown_d = COUNT_INIT;
                    armed_d     = 1'b0;
                end
            end

            PB_PHOTO: begin
                if (sec_tick && (countdown_q != 4'd0)) begin
                    countdown_d = countdown_q - 4'd1;
                end
                if (countdown_q == 4'd0) begin
                    armed_d = 1'b1;
                end
                // armed_q is registered, so a frame in the arming cycle is skipped.
                if (armed_q && frame_done_in) begin
                    cam_we_d = 1'b0;
                    state_d  = PB_CHOOSE;
                end
            end

            PB_CHOOSE: begin
                if (rise_c) begin
                    state_d = PB_THRESHOLD;
                end else if (rise_r && !rise_l) begin
                    filter_d = (filter_q == FILT_LAST) ? 2'd0 : filter_q + 2'd1;
                end else if (rise_l && !rise_r) begin
                    filter_d = (filter_q == 2'd0) ? FILT_LAST : filter_q - 2'd1;
                end
            end

            PB_THRESHOLD: begin
                if (rise_c) begin
                    state_d      = PB_SEND;
                    send_start_d = 1'b1;
                end else if (rise_r && !rise_l) begin
                    threshold_d = thresh_adjust(threshold_q, THR_STEP, 1'b1);
                end else if (rise_l && !rise_r) begin
                    threshold_d = thresh_adjust(threshold_q, THR_STEP, 1'b0);
                end
            end

            PB_SEND: begin
                if (send_done_in) begin
                    state_d     = PB_IDLE;
                    cam_we_d    = 1'b1;
                    threshold_d = THR_INIT;
                end
            end

            default: begin
                state_d     = PB_IDLE;
                cam_we_d    = 1'b1;
                threshold_d = THR_INIT;
            end
        endcase
    end

    assign state_out        = state_q;
    assign cam_write_en_out = cam_we_q;
    assign countdown_out    = countdown_q;
    assign filter_sel_out   = filter_q;
    assign threshold_out    = threshold_q;
    assign send_start_out   = send_start_q;

endmodule

// File: tb/tb_photobooth_ctrl.sv
// Directed bench for photobooth_ctrl: vector table for button handling plus
// hand-written sequences for reset, countdown/capture timing and saturation.
module tb_photobooth_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       start_done_in;
    logic       frame_done_in;
    logic       btnl_in;
    logic       btnr_in;
    logic       btnc_in;
    logic       send_done_in;
    logic [2:0] state_out;
    logic       cam_write_en_out;
    logic [3:0] countdown_out;
    logic [1:0] filter_sel_out;
    logic [7:0] threshold_out;
    logic       send_start_out;

    always #5 clk_in = ~clk_in;

    photobooth_ctrl #(
        .CLK_HZ        (10),
        .COUNTDOWN_S   (3),
        .NUM_FILTERS   (3),
        .THRESH_DEFAULT(128),
        .THRESH_STEP   (8)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_done_in   (start_done_in),
        .frame_done_in   (frame_done_in),
        .btnl_in         (btnl_in),
        .btnr_in         (btnr_in),
        .btnc_in         (btnc_in),
        .send_done_in    (send_done_in),
        .state_out       (state_out),
        .cam_write_en_out(cam_write_en_out),
        .countdown_out   (countdown_out),
        .filter_sel_out  (filter_sel_out),
        .threshold_out   (threshold_out),
        .send_start_out  (send_start_out)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int l, r, c, sd;
        int st, filt, thr, ss, we;
    } vec_t;

    vec_t vecs [28];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply(input int i);
        btnl_in      = (vecs[i].l != 0);
        btnr_in      = (vecs[i].r != 0);
        btnc_in      = (vecs[i].c != 0);
        send_done_in = (vecs[i].sd != 0);
        step();
        check($sformatf("vec%0d state", i),      int'(state_out),        vecs[i].st);
        check($sformatf("vec%0d filter", i),     int'(filter_sel_out),   vecs[i].filt);
        check($sformatf("vec%0d threshold", i),  int'(threshold_out),    vecs[i].thr);
        check($sformatf("vec%0d send_start", i), int'(send_start_out),   vecs[i].ss);
        check($sformatf("vec%0d cam_we", i),     int'(cam_write_en_out), vecs[i].we);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},      int'(state_out),        0);
        check({tag, " cam_we"},     int'(cam_write_en_out), 1);
        check({tag, " countdown"},  int'(countdown_out),    0);
        check({tag, " filter"},     int'(filter_sel_out),   0);
        check({tag, " threshold"},  int'(threshold_out),    128);
        check({tag, " send_start"}, int'(send_start_out),   0);
    endtask

    initial begin
        int exp_thr;
        int exp_cd;

        //            l  r  c  sd   st filt thr  ss we
        vecs[0]  = '{1, 0, 0, 0,   2, 2, 128, 0, 0};  // left wraps 0 -> 2
        vecs[1]  = '{0, 0, 0, 0,   2, 2, 128, 0, 0};
        vecs[2]  = '{0, 1, 0, 0,   2, 0, 128, 0, 0};  // right wraps 2 -> 0
        vecs[3]  = '{0, 0, 0, 0,   2, 0, 128, 0, 0};
        vecs[4]  = '{0, 1, 0, 0,   2, 1, 128, 0, 0};
        vecs[5]  = '{0, 0, 0, 0,   2, 1, 128, 0, 0};
        vecs[6]  = '{1, 1, 0, 0,   2, 1, 128, 0, 0};  // both at once: no change
        vecs[7]  = '{0, 0, 0, 0,   2, 1, 128, 0, 0};
        vecs[8]  = '{0, 1, 0, 0,   2, 2, 128, 0, 0};
        vecs[9]  = '{0, 1, 0, 0,   2, 2, 128, 0, 0};  // held: no second edge
        vecs[10] = '{0, 0, 0, 0,   2, 2, 128, 0, 0};
        vecs[11] = '{1, 0, 0, 0,   2, 1, 128, 0, 0};
        vecs[12] = '{0, 0, 0, 0,   2, 1, 128, 0, 0};
        vecs[13] = '{0, 1, 1, 0,   3, 1, 128, 0, 0};  // centre beats right
        vecs[14] = '{0, 0, 0, 0,   3, 1, 128, 0, 0};
        vecs[15] = '{0, 1, 0, 0,   3, 1, 136, 0, 0};
        vecs[16] = '{0, 0, 0, 0,   3, 1, 136, 0, 0};
        vecs[17] = '{1, 0, 0, 0,   3, 1, 128, 0, 0};
        vecs[18] = '{0, 0, 0, 0,   3, 1, 128, 0, 0};
        vecs[19] = '{0, 1, 1, 0,   4, 1, 0,   1, 0};  // to SEND, threshold untouched
        vecs[20] = '{0, 0, 0, 0,   4, 1, 0,   0, 0};  // send_start is one cycle
        vecs[21] = '{1, 0, 0, 0,   4, 1, 0,   0, 0};
        vecs[22] = '{0, 0, 0, 0,   4, 1, 0,   0, 0};
        vecs[23] = '{0, 1, 0, 0,   4, 1, 0,   0, 0};
        vecs[24] = '{0, 0, 1, 0,   4, 1, 0,   0, 0};
        vecs[25] = '{0, 0, 0, 0,   4, 1, 0,   0, 0};
        vecs[26] = '{0, 0, 0, 1,   0, 1, 128, 0, 1};  // send done -> IDLE
        vecs[27] = '{0, 0, 0, 0,   0, 1, 128, 0, 1};

        rst_in        = 1'b1;
        start_done_in = 1'b0;
        frame_done_in = 1'b0;
        btnl_in       = 1'b0;
        btnr_in       = 1'b0;
        btnc_in       = 1'b1;
        send_done_in  = 1'b0;

        // Reset with centre held, then release.
        repeat (3) step();
        check_reset_values("in reset");
        rst_in = 1'b0;
        step();
        step();
        check("post reset state", int'(state_out), 0);
        check("post reset threshold", int'(threshold_out), 128);
        check("post reset cam_we", int'(cam_write_en_out), 1);
        btnc_in = 1'b0;
        step();
        check("idle after release", int'(state_out), 0);

        // Countdown, arming and frame-aligned capture.
        start_done_in = 1'b1;
        step();
        start_done_in = 1'b0;
        check("photo entry state", int'(state_out), 1);
        check("photo entry countdown", int'(countdown_out), 3);
        check("photo entry cam_we", int'(cam_write_en_out), 1);
        for (int k = 2; k <= 39; k++) begin
            frame_done_in = ((k % 7) == 4);
            step();
            frame_done_in = 1'b0;
            exp_cd = (k <= 10) ? 3 : (k <= 20) ? 2 : (k <= 30) ? 1 : 0;
            check($sformatf("photo cyc%0d countdown", k), int'(countdown_out), exp_cd);
            check($sformatf("photo cyc%0d state", k), int'(state_out), (k >= 39) ? 2 : 1);
            check($sformatf("photo cyc%0d cam_we", k), int'(cam_write_en_out), (k >= 39) ? 0 : 1);
        end

        // Filter selection and first threshold steps.
        for (int i = 0; i <= 18; i++) apply(i);

        // Saturate upward, then all the way down.
        exp_thr = 128;
        for (int i = 0; i < 20; i++) begin
            btnr_in = 1'b1;
            step();
            exp_thr = (exp_thr + 8 > 255) ? 255 : exp_thr + 8;
            check($sformatf("thr up press%0d", i), int'(threshold_out), exp_thr);
            btnr_in = 1'b0;
            step();
        end
        check("thr saturated high", int'(threshold_out), 255);
        for (int i = 0; i < 40; i++) begin
            btnl_in = 1'b1;
            step();
            exp_thr = (exp_thr - 8 < 0) ? 0 : exp_thr - 8;
            check($sformatf("thr down press%0d", i), int'(threshold_out), exp_thr);
            btnl_in = 1'b0;
            step();
        end
        check("thr saturated low", int'(threshold_out), 0);
        check("thr still in state", int'(state_out), 3);

        // Hand-off to SEND and back to IDLE.
        for (int i = 19; i <= 27; i++) apply(i);

        // Reset in the middle of a countdown.
        start_done_in = 1'b1;
        step();
        start_done_in = 1'b0;
        check("rerun countdown", int'(countdown_out), 3);
        repeat (10) step();
        check("rerun countdown after 1s", int'(countdown_out), 2);
        check("rerun cam_we", int'(cam_write_en_out), 1);
        rst_in = 1'b1;
        step();
        check_reset_values("mid reset");
        rst_in = 1'b0;
        step();
        check("after mid reset state", int'(state_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
